// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, requester ids, arbiter states
// and the round-robin pick used by the write-port arbiter.
package rf_pkg;

  localparam int RF_ADDR_W = 2;
  localparam int RF_DATA_W = 8;
  localparam int RF_DEPTH  = 4;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BURST0 = 2'd1,
    ARB_BURST1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic hit;
    logic id;
  } grant_t;

  // On a tie the requester that did not win last time gets the port.
  function automatic grant_t rr_pick(input logic v0, input logic v1, input logic last_grant);
    grant_t g;
    g.hit = v0 | v1;
    if (v0 && v1)
      g.id = ~last_grant;
    else if (v1)
      g.id = REQ_LD;
    else
      g.id = REQ_ALU;
    return g;
  endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// writeback and the load unit, with optional bounded locked bursts.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wren,
  output logic              wr_owner,
  output logic              burst_active
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic             BURST_EN = (MAX_BURST > 1);

  arb_state_t        state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  grant_t            gnt;
  logic              xfer;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // During a burst only the owner can be granted; otherwise round-robin.
  always_comb begin
    gnt = '0;
    case (state)
      ARB_IDLE:   gnt = rr_pick(req0_valid, req1_valid, last_grant);
      ARB_BURST0: begin
        gnt.hit = req0_valid;
        gnt.id  = REQ_ALU;
      end
      ARB_BURST1: begin
        gnt.hit = req1_valid;
        gnt.id  = REQ_LD;
      end
      default:    gnt = '0;
    endcase
  end

  // Readies are masked by reset so nothing is accepted while it is held.
  assign xfer       = gnt.hit & rst_n;
  assign req0_ready = xfer & (gnt.id == REQ_ALU);
  assign req1_ready = xfer & (gnt.id == REQ_LD);

  assign sel_lock = (gnt.id == REQ_LD) ? req1_lock : req0_lock;
  assign sel_addr = (gnt.id == REQ_LD) ? req1_addr : req0_addr;
  assign sel_data = (gnt.id == REQ_LD) ? req1_data : req0_data;
  assign cnt_inc  = cnt + CNT_W'(1);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    case (state)
      ARB_IDLE: begin
        if (gnt.hit) begin
          last_grant_nxt = gnt.id;
          if (sel_lock && BURST_EN) begin
            state_nxt = (gnt.id == REQ_LD) ? ARB_BURST1 : ARB_BURST0;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ARB_BURST0, ARB_BURST1: begin
        // The owner dropping valid, releasing lock or hitting the limit ends the burst.
        if (!gnt.hit || !sel_lock || (cnt_inc == CNT_MAX)) begin
          state_nxt = ARB_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_LD;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr    <= '0;
      wdata    <= '0;
      wren     <= 1'b0;
      wr_owner <= 1'b0;
    end else begin
      wren <= xfer;
      if (xfer) begin
        waddr    <= sel_addr;
        wdata    <= sel_data;
        wr_owner <= gnt.id;
      end
    end
  end

  assign burst_active = (state != ARB_IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized checks of rf_write_arbiter against a transaction
// level model of the round-robin / burst rules.
module tb_rf_write_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v[2];
  logic       lk[2];
  logic [1:0] ad[2];
  logic [7:0] dt[2];
  logic       ready0, ready1, wren, wr_owner, burst_active;
  logic [1:0] waddr;
  logic [7:0] wdata;

  int compared   = 0;
  int mismatched = 0;

  int         m_owner;
  int         m_cnt;
  int         m_last;
  int         last_g;
  logic       e_wren;
  logic [1:0] e_waddr;
  logic [7:0] e_wdata;
  logic       e_owner;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(8), .ADDR_W(2), .MAX_BURST(MAXB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0_valid(v[0]),
    .req0_lock(lk[0]),
    .req0_addr(ad[0]),
    .req0_data(dt[0]),
    .req0_ready(ready0),
    .req1_valid(v[1]),
    .req1_lock(lk[1]),
    .req1_addr(ad[1]),
    .req1_data(dt[1]),
    .req1_ready(ready1),
    .waddr(waddr),
    .wdata(wdata),
    .wren(wren),
    .wr_owner(wr_owner),
    .burst_active(burst_active)
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = 1;
    last_g  = -1;
    e_wren  = 1'b0;
    e_waddr = 2'd0;
    e_wdata = 8'd0;
    e_owner = 1'b0;
  endtask

  function automatic int modelGrant();
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    if (v[0] && v[1]) return 1 - m_last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic modelStep(input int g);
    if (g >= 0) begin
      e_wren  = 1'b1;
      e_waddr = ad[g];
      e_wdata = dt[g];
      e_owner = (g == 1);
      if (m_owner < 0) begin
        m_last = g;
        if (lk[g] && MAXB > 1) begin
          m_owner = g;
          m_cnt   = 1;
        end
      end else begin
        m_cnt++;
        if (!lk[g] || m_cnt == MAXB) begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end else begin
      e_wren  = 1'b0;
      m_owner = -1;
      m_cnt   = 0;
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic l0, input logic [1:0] a0, input logic [7:0] d0,
                               input logic v1, input logic l1, input logic [1:0] a1, input logic [7:0] d1);
    v[0] = v0; lk[0] = l0; ad[0] = a0; dt[0] = d0;
    v[1] = v1; lk[1] = l1; ad[1] = a1; dt[1] = d1;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic checkOutput(input string tag);
    int g;
    @(negedge clk);
    g = modelGrant();
    checkEq({tag, ".ready0"}, 32'(ready0), 32'(g == 0));
    checkEq({tag, ".ready1"}, 32'(ready1), 32'(g == 1));
    checkEq({tag, ".burst_active"}, 32'(burst_active), 32'(m_owner >= 0));
    checkEq({tag, ".wren"}, 32'(wren), 32'(e_wren));
    checkEq({tag, ".waddr"}, 32'(waddr), 32'(e_waddr));
    checkEq({tag, ".wdata"}, 32'(wdata), 32'(e_wdata));
    checkEq({tag, ".wr_owner"}, 32'(wr_owner), 32'(e_owner));
    @(posedge clk);
    modelStep(g);
    last_g = g;
    #1;
  endtask

  initial begin
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkEq("reset.wren", 32'(wren), 32'd0);
    checkEq("reset.waddr", 32'(waddr), 32'd0);
    checkEq("reset.wdata", 32'(wdata), 32'd0);
    checkEq("reset.burst_active", 32'(burst_active), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single write");
    applyStimulus(1, 0, 2'd2, 8'h5A, 0, 0, 0, 0);
    checkOutput("single");
    checkEq("single.wdata_direct", 32'(wdata), 32'h5A);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_out");
    checkOutput("single_idle");

    $display("[TB] alternating ties");
    applyStimulus(1, 0, 2'd1, 8'h11, 1, 0, 2'd3, 8'h33);
    for (int i = 0; i < 6; i++) checkOutput("alt");

    $display("[TB] req0 locked burst");
    applyStimulus(1, 1, 2'd0, 8'h40, 1, 0, 2'd3, 8'h33);
    for (int i = 0; i < 7; i++) checkOutput("burst0");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("burst0_drain");

    $display("[TB] req1 burst dropping valid");
    applyStimulus(0, 0, 0, 0, 1, 1, 2'd1, 8'hC1);
    checkOutput("burst1_a");
    applyStimulus(1, 0, 2'd2, 8'hD0, 1, 1, 2'd1, 8'hC2);
    checkOutput("burst1_b");
    applyStimulus(1, 0, 2'd2, 8'hD0, 0, 0, 0, 0);
    checkOutput("burst1_drop");
    checkEq("burst1.exit_direct", 32'(burst_active), 32'd0);
    checkOutput("burst1_req0");
    checkEq("burst1.req0_direct", 32'(wr_owner), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("burst1_idle");

    $display("[TB] async reset mid-burst");
    applyStimulus(1, 1, 2'd1, 8'hE0, 0, 0, 0, 0);
    checkOutput("rst_a");
    checkOutput("rst_b");
    #2 rst_n = 1'b0;
    #1;
    checkEq("rst.wren", 32'(wren), 32'd0);
    checkEq("rst.burst_active", 32'(burst_active), 32'd0);
    checkEq("rst.ready0", 32'(ready0), 32'd0);
    checkEq("rst.ready1", 32'(ready1), 32'd0);
    modelReset();
    applyStimulus(1, 0, 2'd1, 8'h01, 1, 0, 2'd2, 8'h02);
    @(posedge clk);
    #3 rst_n = 1'b1;
    checkOutput("rst_tie");
    checkEq("rst.tie_owner_direct", 32'(wr_owner), 32'd0);

    $display("[TB] same address collision");
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd3, 8'h77);
    checkOutput("coll_pre");
    applyStimulus(1, 0, 2'd0, 8'hAA, 1, 0, 2'd0, 8'hBB);
    checkOutput("coll_a");
    checkEq("coll.first_direct", 32'(wdata), 32'hAA);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd0, 8'hBB);
    checkOutput("coll_b");
    checkEq("coll.second_direct", 32'(wdata), 32'hBB);
    checkEq("coll.addr_direct", 32'(waddr), 32'd0);

    $display("[TB] randomized traffic");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    last_g = -1;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (v[r] && last_g == r) v[r] = 1'b0;
        if (!v[r] && $urandom_range(0, 2) != 0) begin
          v[r]  = 1'b1;
          lk[r] = 1'($urandom_range(0, 1));
          ad[r] = 2'($urandom_range(0, 3));
          dt[r] = 8'($urandom_range(0, 255));
        end
      end
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
